// File: rtl/icb_arbt.sv
// icb_arbt: round-robin arbiter sharing one downstream ICB port among
// ARBT_NUM masters. Exactly one transaction is in flight at a time; the
// grant is held from command acceptance through the response handshake,
// so responses are always routed back to the master that issued the command.
module icb_arbt #(
    parameter int ARBT_NUM = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [ARBT_NUM-1:0]      i_bus_icb_cmd_valid,
    output logic [ARBT_NUM-1:0]      i_bus_icb_cmd_ready,
    input  logic [ARBT_NUM-1:0]      i_bus_icb_cmd_read,
    input  logic [ARBT_NUM*16-1:0]   i_bus_icb_cmd_addr,
    input  logic [ARBT_NUM*8-1:0]    i_bus_icb_cmd_wdata,
    output logic [ARBT_NUM-1:0]      i_bus_icb_rsp_valid,
    input  logic [ARBT_NUM-1:0]      i_bus_icb_rsp_ready,
    output logic [ARBT_NUM-1:0]      i_bus_icb_rsp_err,
    output logic [ARBT_NUM*8-1:0]    i_bus_icb_rsp_rdata,

    output logic                     o_icb_cmd_valid,
    input  logic                     o_icb_cmd_ready,
    output logic                     o_icb_cmd_read,
    output logic [15:0]              o_icb_cmd_addr,
    output logic [7:0]               o_icb_cmd_wdata,
    input  logic                     o_icb_rsp_valid,
    output logic                     o_icb_rsp_ready,
    input  logic                     o_icb_rsp_err,
    input  logic [7:0]               o_icb_rsp_rdata,

    output logic [ARBT_NUM-1:0]      arbt_grant,
    output logic                     arbt_busy
);

    localparam logic [ARBT_NUM-1:0] ONE = ARBT_NUM'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ARBT_NUM-1:0] grant_q, grant_d;
    logic [ARBT_NUM-1:0] rrPtr_q, rrPtr_d;

    logic [ARBT_NUM-1:0] upperReq;
    logic [ARBT_NUM-1:0] upperPick;
    logic [ARBT_NUM-1:0] anyPick;
    logic [ARBT_NUM-1:0] winner;

    logic                selValid;
    logic                selRead;
    logic [15:0]         selAddr;
    logic [7:0]          selWdata;
    logic                selRspReady;

    // Round-robin pick: lowest request at or above the one-hot pointer,
    // otherwise wrap around to the lowest request overall. x & -x isolates
    // the lowest set bit.
    assign upperReq  = i_bus_icb_cmd_valid & ~(rrPtr_q - ONE);
    assign upperPick = upperReq & (~upperReq + ONE);
    assign anyPick   = i_bus_icb_cmd_valid & (~i_bus_icb_cmd_valid + ONE);
    assign winner    = (|upperReq) ? upperPick : anyPick;

    // Select the granted master's command and response-ready signals.
    always_comb begin
        selValid    = 1'b0;
        selRead     = 1'b0;
        selAddr     = 16'h0000;
        selWdata    = 8'h00;
        selRspReady = 1'b0;
        for (int k = 0; k < ARBT_NUM; k++) begin
            if (grant_q[k]) begin
                selValid    = i_bus_icb_cmd_valid[k];
                selRead     = i_bus_icb_cmd_read[k];
                selAddr     = i_bus_icb_cmd_addr[k*16 +: 16];
                selWdata    = i_bus_icb_cmd_wdata[k*8 +: 8];
                selRspReady = i_bus_icb_rsp_ready[k];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant through CMD and RSP,
    // and rotate the priority pointer past the master just served.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rrPtr_d = rrPtr_q;
        case (state_q)
            IDLE: begin
                if (|i_bus_icb_cmd_valid) begin
                    grant_d = winner;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (selValid && o_icb_cmd_ready) begin
                    state_d = RSP;
                end else if (!selValid) begin
                    // Master withdrew its request; give up without touching priority.
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            RSP: begin
                if (o_icb_rsp_valid && selRspReady) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rrPtr_d = {grant_q[ARBT_NUM-2:0], grant_q[ARBT_NUM-1]};
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Route command and response handshakes between the granted master and downstream.
    always_comb begin
        o_icb_cmd_valid     = 1'b0;
        o_icb_cmd_read      = selRead;
        o_icb_cmd_addr      = selAddr;
        o_icb_cmd_wdata     = selWdata;
        o_icb_rsp_ready     = 1'b0;
        i_bus_icb_cmd_ready = '0;
        i_bus_icb_rsp_valid = '0;
        i_bus_icb_rsp_err   = '0;
        i_bus_icb_rsp_rdata = '0;
        if (state_q == CMD) begin
            o_icb_cmd_valid     = selValid;
            i_bus_icb_cmd_ready = grant_q & {ARBT_NUM{o_icb_cmd_ready}};
        end
        if (state_q == RSP) begin
            o_icb_rsp_ready     = selRspReady;
            i_bus_icb_rsp_valid = grant_q & {ARBT_NUM{o_icb_rsp_valid}};
            i_bus_icb_rsp_err   = grant_q & {ARBT_NUM{o_icb_rsp_err}};
            for (int k = 0; k < ARBT_NUM; k++) begin
                if (grant_q[k]) begin
                    i_bus_icb_rsp_rdata[k*8 +: 8] = o_icb_rsp_rdata;
                end
            end
        end
    end

    assign arbt_grant = grant_q;
    assign arbt_busy  = (state_q != IDLE);

    // State, grant and priority-pointer registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rrPtr_q <= ONE;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rrPtr_q <= rrPtr_d;
        end
    end

endmodule

// File: doc/icb_arbt.md
Name: icb_arbt

Overview:
- Round-robin ICB arbiter: ARBT_NUM masters share one downstream ICB port, 16-bit address, 8-bit data.
- Sits in front of the ESC register split fabric. Example masters: EtherCAT frame processor and PDI.
- One transaction outstanding at a time. The grant is held from command acceptance until the response handshake, so responses never need reordering.

Parameters:
- ARBT_NUM, 2, number of requesting masters (2..8).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_bus_icb_cmd_valid  in  ARBT_NUM  per-master command valid
- i_bus_icb_cmd_ready  out  ARBT_NUM  per-master command ready
- i_bus_icb_cmd_read  in  ARBT_NUM  per-master read(1)/write(0)
- i_bus_icb_cmd_addr  in  ARBT_NUM*16  per-master address; master k at [k*16+15:k*16]
- i_bus_icb_cmd_wdata  in  ARBT_NUM*8  per-master write data
- i_bus_icb_rsp_valid  out  ARBT_NUM  per-master response valid
- i_bus_icb_rsp_ready  in  ARBT_NUM  per-master response ready
- i_bus_icb_rsp_err  out  ARBT_NUM  per-master response error
- i_bus_icb_rsp_rdata  out  ARBT_NUM*8  per-master read data
- o_icb_cmd_valid  out  1  downstream command valid
- o_icb_cmd_ready  in  1  downstream command ready
- o_icb_cmd_read  out  1  downstream read flag
- o_icb_cmd_addr  out  16  downstream address
- o_icb_cmd_wdata  out  8  downstream write data
- o_icb_rsp_valid  in  1  downstream response valid
- o_icb_rsp_ready  out  1  downstream response ready
- o_icb_rsp_err  in  1  downstream response error
- o_icb_rsp_rdata  in  8  downstream read data
- arbt_grant  out  ARBT_NUM  one-hot current grant; 0 when IDLE
- arbt_busy  out  1  1 in CMD or RSP

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous active-low.
- Reset values: state=IDLE, grant=0, rr_ptr=one-hot bit 0 (master 0 highest priority), all valid/ready outputs 0, arbt_busy=0.
- Reset mid-transaction: abandons the transaction and returns to these values. No response is delivered.
- Registered state machine with three states: IDLE, CMD, RSP.
- IDLE:
  - No ready asserted to any master; o_icb_cmd_valid=0.
  - If any i_bus_icb_cmd_valid bit is set, latch the winner into grant and go to CMD.
  - Winner is the first set bit searching upward from the rr_ptr position, wrapping past ARBT_NUM-1 to 0.
  - Arbitration latency: 1 cycle from master valid to downstream valid.
- CMD:
  - o_icb_cmd_valid = i_bus_icb_cmd_valid[g]; read, addr and wdata muxed combinationally from master g.
  - i_bus_icb_cmd_ready[g] = o_icb_cmd_ready; all other ready bits 0.
  - On handshake (valid[g] & o_icb_cmd_ready): go to RSP.
  - If valid[g] drops before handshake (protocol violation, tolerated): go to IDLE, grant cleared, rr_ptr unchanged.
- RSP:
  - i_bus_icb_rsp_valid[g] = o_icb_rsp_valid; o_icb_rsp_ready = i_bus_icb_rsp_ready[g].
  - err and rdata routed to master g only. Non-granted masters see rsp_valid=0, err=0, rdata=0.
  - On response handshake: go to IDLE, clear grant, rr_ptr = grant rotated left by 1 (bit ARBT_NUM-1 wraps to bit 0).
  - A response arriving in the same cycle as the command handshake is not possible: RSP is entered on the following cycle. Downstream holds rsp_valid until ready.
- No command is accepted from any master while in CMD or RSP. New requests wait, and their valid must be held.
- A master may hold valid continuously. After its transaction it re-arbitrates in IDLE at lowest priority.
- Sustained throughput: one transaction per 3 cycles minimum (IDLE, CMD, RSP), given zero-wait downstream.
- arbt_grant reflects the registered grant. arbt_busy = (state != IDLE).

Test Plan:
- Reset, then master 0 write addr 0x0120 wdata 0x5A; downstream ready=1, rsp 1 cycle later → o_icb_cmd_valid high cycle 2 with addr 0x0120, wdata 0x5A; rsp to master 0 only; arbt_grant 0b01→0b00.
- Both masters valid continuously, reads to 0x0010 (m0) and 0x0800 (m1) → downstream sees 0x0010, 0x0800, 0x0010, 0x0800 alternating; no master granted twice in a row.
- Master 1 read 0x0910; downstream holds cmd_ready=0 for 4 cycles, then rsp rdata 0xC3 err=1 → master 1 receives rdata 0xC3, err=1; master 0 rsp_valid stays 0; master 0 cmd_ready stays 0 throughout.
- Master 0 holds rsp_ready=0 for 3 cycles while downstream rsp_valid=1 → o_icb_rsp_ready=0 for those cycles; state stays RSP; master 1 request is not accepted until the response handshake.
- rst_n asserted while in RSP with master 1 granted → next edge: arbt_busy=0, grant=0, rr_ptr=master 0; the new master-1 request is served from IDLE normally.
- ARBT_NUM=4, masters 1 and 3 valid, rr_ptr at bit 2 → master 3 granted first, then master 1.
